// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//   Multi-digit BCD score counter with a best-score register and a registered
//   seven-segment driver for the board HEX displays.
//
//   Parameters
//     NUM_DIGITS     : number of BCD digits / displays (1..6)
//     BLANK_LEADING  : 1 = blank zero digits above the most significant nonzero
//                      digit (digit 0 is never blanked)
//     SEG_ACTIVE_LOW : 1 = segment bit 0 lights the segment, 0 = inverted
//
//   Ports
//     clk        : system clock
//     reset_n    : asynchronous active-low reset
//     inc        : score request, one increment per 0->1 transition
//     clear      : synchronous clear of current score and sticky flags
//     show_best  : 1 = display best score, 0 = display current score
//     score_bcd  : current score, digit i at [4i+3:4i], digit 0 = units
//     best_bcd   : best score since reset
//     new_best   : sticky, best updated since last clear
//     overflow   : sticky, increment requested while saturated at all nines
//     hex        : segments of digit i at [7i+6:7i], bit order g..a
// -----------------------------------------------------------------------------
module score_display #(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter bit          BLANK_LEADING  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inc,
  input  logic                    clear,
  input  logic                    show_best,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] best_bcd,
  output logic                    new_best,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned HexW = 7 * NUM_DIGITS;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Single digit to segments (g..a). Codes 10..15 never occur internally but
  // fall back to blank so a corrupted digit is visibly dark rather than wrong.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit,
                                            input logic       blank);
    logic [6:0] seg_n;
    case (digit)
      4'd0:    seg_n = 7'b1000000;
      4'd1:    seg_n = 7'b1111001;
      4'd2:    seg_n = 7'b0100100;
      4'd3:    seg_n = 7'b0110000;
      4'd4:    seg_n = 7'b0011001;
      4'd5:    seg_n = 7'b0010010;
      4'd6:    seg_n = 7'b0000010;
      4'd7:    seg_n = 7'b1111000;
      4'd8:    seg_n = 7'b0000000;
      4'd9:    seg_n = 7'b0010000;
      default: seg_n = 7'b1111111;
    endcase
    if (blank) seg_n = 7'b1111111;
    return SEG_ACTIVE_LOW ? seg_n : ~seg_n;
  endfunction

  // Whole-number encode with leading-zero blanking. Walks from the MSD down,
  // tracking whether every digit so far (inclusive) has been zero.
  function automatic logic [HexW-1:0] encode_all(input logic [BcdW-1:0] bcd);
    logic [HexW-1:0] segs;
    logic            upper_zero;
    segs       = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (bcd[4*i +: 4] == 4'd0);
      segs[7*i +: 7] = seg_encode(bcd[4*i +: 4],
                                  BLANK_LEADING && upper_zero && (i != 0));
    end
    return segs;
  endfunction

  // BCD +1 with ripple carry; an all-nines input wraps to zero (callers
  // saturate before using the result in that case).
  function automatic logic [BcdW-1:0] bcd_increment(input logic [BcdW-1:0] bcd);
    logic [BcdW-1:0] result;
    logic            carry;
    result = bcd;
    carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

  function automatic logic bcd_all_nines(input logic [BcdW-1:0] bcd);
    logic nines;
    nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nines = nines && (bcd[4*i +: 4] == 4'd9);
    end
    return nines;
  endfunction

  // Display pattern for an all-zero source: "0" on digit 0, leading digits
  // blank or "0" depending on BLANK_LEADING.
  localparam logic [HexW-1:0] HexReset = encode_all('0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            inc_q;
  logic [BcdW-1:0] score_q,    score_d;
  logic [BcdW-1:0] best_q,     best_d;
  logic            new_best_q, new_best_d;
  logic            overflow_q, overflow_d;
  logic [HexW-1:0] hex_q,      hex_d;

  logic            inc_event;
  logic [BcdW-1:0] score_plus1;
  logic            saturated;

  assign inc_event   = inc & ~inc_q;
  assign score_plus1 = bcd_increment(score_q);
  assign saturated   = bcd_all_nines(score_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the if/else leaves it unassigned and no latch is inferred.
    score_d    = score_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    overflow_d = overflow_q;

    if (clear) begin
      score_d    = '0;
      new_best_d = 1'b0;
      overflow_d = 1'b0;
    end else if (inc_event) begin
      if (saturated) begin
        overflow_d = 1'b1;
      end else begin
        score_d = score_plus1;
        // Valid BCD with MSD at the top compares correctly as plain unsigned.
        if (score_plus1 > best_q) begin
          best_d     = score_plus1;
          new_best_d = 1'b1;
        end
      end
    end

    // Display registers the current state, so hex trails score by one cycle.
    hex_d = encode_all(show_best ? best_q : score_q);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_q      <= 1'b0;
      score_q    <= '0;
      best_q     <= '0;
      new_best_q <= 1'b0;
      overflow_q <= 1'b0;
      hex_q      <= HexReset;
    end else begin
      inc_q      <= inc;   // tracks inc even during clear
      score_q    <= score_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
      overflow_q <= overflow_d;
      hex_q      <= hex_d;
    end
  end

  assign score_bcd = score_q;
  assign best_bcd  = best_q;
  assign new_best  = new_best_q;
  assign overflow  = overflow_q;
  assign hex       = hex_q;

endmodule

// File: tb/tb_score_display.sv
// -----------------------------------------------------------------------------
// tb_score_display
//   Directed self-checking bench for score_display with default parameters
//   (3 digits, leading-zero blanking, active-low segments). Inputs change and
//   outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_score_display;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic        clk;
  logic        reset_n;
  logic        inc;
  logic        clear;
  logic        show_best;
  logic [11:0] score_bcd;
  logic [11:0] best_bcd;
  logic        new_best;
  logic        overflow;
  logic [20:0] hex;

  int n_checks = 0;
  int n_fail   = 0;

  score_display #(
    .NUM_DIGITS    (3),
    .BLANK_LEADING (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (inc),
    .clear    (clear),
    .show_best(show_best),
    .score_bcd(score_bcd),
    .best_bcd (best_bcd),
    .new_best (new_best),
    .overflow (overflow),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    inc = 1'b0; clear = 1'b0; show_best = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle pulse per count; returns on a falling edge with inc low.
  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) inc = 1'b1;
      @(negedge clk) inc = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    inc = 1'b0; clear = 1'b0; show_best = 1'b0;
    #12;
    n_checks++;
    if (score_bcd !== 12'h000) begin
      n_fail++; $display("FAIL reset_score: got %h expected %h", score_bcd, 12'h000);
    end
    n_checks++;
    if (best_bcd !== 12'h000) begin
      n_fail++; $display("FAIL reset_best: got %h expected %h", best_bcd, 12'h000);
    end
    n_checks++;
    if ({new_best, overflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00", {new_best, overflow});
    end
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_BLANK, SEG_0}) begin
      n_fail++; $display("FAIL reset_hex: got %h expected %h", hex, {SEG_BLANK, SEG_BLANK, SEG_0});
    end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_pulse();
    @(negedge clk) inc = 1'b1;
    @(negedge clk) inc = 1'b0;
    // One edge since the rise: score updated, display not yet.
    n_checks++;
    if (score_bcd !== 12'h001) begin
      n_fail++; $display("FAIL pulse_score: got %h expected %h", score_bcd, 12'h001);
    end
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_BLANK, SEG_0}) begin
      n_fail++; $display("FAIL pulse_hex_lag: got %h expected %h", hex, {SEG_BLANK, SEG_BLANK, SEG_0});
    end
    @(negedge clk);
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_BLANK, SEG_1}) begin
      n_fail++; $display("FAIL pulse_hex: got %h expected %h", hex, {SEG_BLANK, SEG_BLANK, SEG_1});
    end
    n_checks++;
    if (best_bcd !== 12'h001 || new_best !== 1'b1) begin
      n_fail++; $display("FAIL pulse_best: got %h/%b expected 001/1", best_bcd, new_best);
    end
  endtask

  task automatic test_hold();
    @(negedge clk) inc = 1'b1;
    repeat (10) @(negedge clk);
    inc = 1'b0;
    @(negedge clk);
    n_checks++;
    if (score_bcd !== 12'h002) begin
      n_fail++; $display("FAIL hold_once: got %h expected %h", score_bcd, 12'h002);
    end
  endtask

  task automatic test_twelve_pulses();
    do_reset();
    pulse(12);
    @(negedge clk);
    n_checks++;
    if (score_bcd !== 12'h012) begin
      n_fail++; $display("FAIL twelve_score: got %h expected %h", score_bcd, 12'h012);
    end
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_1, SEG_2}) begin
      n_fail++; $display("FAIL twelve_hex: got %h expected %h", hex, {SEG_BLANK, SEG_1, SEG_2});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    pulse(999);
    @(negedge clk);
    n_checks++;
    if (score_bcd !== 12'h999 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL sat_reach: got %h/%b expected 999/0", score_bcd, overflow);
    end
    n_checks++;
    if (hex !== {SEG_9, SEG_9, SEG_9}) begin
      n_fail++; $display("FAIL sat_hex: got %h expected %h", hex, {SEG_9, SEG_9, SEG_9});
    end
    pulse(1);
    n_checks++;
    if (score_bcd !== 12'h999 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold: got %h/%b expected 999/1", score_bcd, overflow);
    end
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    n_checks++;
    if (score_bcd !== 12'h000 || overflow !== 1'b0 || new_best !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: got %h/%b/%b expected 000/0/0", score_bcd, overflow, new_best);
    end
    n_checks++;
    if (best_bcd !== 12'h999) begin
      n_fail++; $display("FAIL sat_best_kept: got %h expected %h", best_bcd, 12'h999);
    end
  endtask

  task automatic test_new_best();
    do_reset();
    pulse(5);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    pulse(3);
    n_checks++;
    if (best_bcd !== 12'h005 || new_best !== 1'b0) begin
      n_fail++; $display("FAIL nb_below: got %h/%b expected 005/0", best_bcd, new_best);
    end
    pulse(2);
    // Equal to best is not a new best.
    n_checks++;
    if (score_bcd !== 12'h005 || new_best !== 1'b0) begin
      n_fail++; $display("FAIL nb_equal: got %h/%b expected 005/0", score_bcd, new_best);
    end
    pulse(1);
    n_checks++;
    if (best_bcd !== 12'h006 || new_best !== 1'b1) begin
      n_fail++; $display("FAIL nb_exceed: got %h/%b expected 006/1", best_bcd, new_best);
    end
  endtask

  task automatic test_clear_priority();
    // Score is 006 here; clear and an inc rise share one edge.
    @(negedge clk);
    clear = 1'b1;
    inc   = 1'b1;
    @(negedge clk) clear = 1'b0;
    n_checks++;
    if (score_bcd !== 12'h000 || best_bcd !== 12'h006) begin
      n_fail++; $display("FAIL clr_prio: got %h/%h expected 000/006", score_bcd, best_bcd);
    end
    // inc still high after clear releases: no further increment.
    repeat (2) @(negedge clk);
    n_checks++;
    if (score_bcd !== 12'h000) begin
      n_fail++; $display("FAIL clr_held_inc: got %h expected %h", score_bcd, 12'h000);
    end
    inc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_show_best();
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_BLANK, SEG_0}) begin
      n_fail++; $display("FAIL show_cur: got %h expected %h", hex, {SEG_BLANK, SEG_BLANK, SEG_0});
    end
    show_best = 1'b1;
    #1;
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_BLANK, SEG_0}) begin
      n_fail++; $display("FAIL show_best_early: got %h expected %h", hex, {SEG_BLANK, SEG_BLANK, SEG_0});
    end
    @(negedge clk);
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_BLANK, SEG_6}) begin
      n_fail++; $display("FAIL show_best: got %h expected %h", hex, {SEG_BLANK, SEG_BLANK, SEG_6});
    end
    show_best = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(47);
    @(negedge clk);
    n_checks++;
    if (score_bcd !== 12'h047 || hex !== {SEG_BLANK, SEG_4, SEG_7}) begin
      n_fail++; $display("FAIL ar_pre: got %h/%h expected 047/%h", score_bcd, hex, {SEG_BLANK, SEG_4, SEG_7});
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (score_bcd !== 12'h000 || best_bcd !== 12'h000 || new_best !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ar_state: got %h/%h/%b/%b expected 000/000/0/0", score_bcd, best_bcd, new_best, overflow);
    end
    n_checks++;
    if (hex !== {SEG_BLANK, SEG_BLANK, SEG_0}) begin
      n_fail++; $display("FAIL ar_hex: got %h expected %h", hex, {SEG_BLANK, SEG_BLANK, SEG_0});
    end
    // inc held high through reset release counts exactly once.
    inc = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (score_bcd !== 12'h001 || best_bcd !== 12'h001) begin
      n_fail++; $display("FAIL ar_release: got %h/%h expected 001/001", score_bcd, best_bcd);
    end
    inc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_hold();
    test_twelve_pulses();
    test_saturation();
    test_new_best();
    test_clear_priority();
    test_show_best();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
